// File: rtl/lfsr_prng_mm.sv
// lfsr_prng_mm: memory-mapped Fibonacci LFSR word generator; LFSR_PREFETCH_EN enables background refill
module lfsr_prng_mm #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] TAPS         = 32'h8020_0003,
    parameter int          STEPS        = 32,
    parameter logic [31:0] SEED_DEFAULT = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  reg_seed_we,
    input  logic [31:0] reg_seed_di,
    output logic [31:0] reg_seed_do,
    input  logic        reg_dat_re,
    output logic [31:0] reg_dat_do,
    output logic        reg_dat_wait
);
    localparam logic [WIDTH-1:0] TAP_M  = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W = SEED_DEFAULT[WIDTH-1:0];
    localparam logic [7:0]       LAST   = 8'(STEPS - 1);
`ifdef LFSR_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [31:0]      seed, seed_n;
    logic [WIDTH-1:0] lfsr, lfsr_n;
    logic [7:0]       cnt, cnt_n;
    logic             ready, ready_n;
    logic             reload, reload_n;
    logic             fb;
    logic             start;

    assign reg_seed_do  = seed;
    assign reg_dat_do   = 32'(lfsr);
    assign reg_dat_wait = reg_dat_re & ~ready;
    assign fb           = ^(lfsr & TAP_M);
    assign start        = ~ready & (PREFETCH | reg_dat_re);

    // byte-lane merge of seed writes into the seed register
    always_comb begin
        seed_n = seed;
        for (int i = 0; i < 4; i++)
            if (reg_seed_we[i]) seed_n[8*i +: 8] = reg_seed_di[8*i +: 8];
    end

    // generator FSM: reload in IDLE, STEPS shifts per word, ready raised with the final shift
    always_comb begin
        state_n  = state;
        lfsr_n   = lfsr;
        cnt_n    = cnt;
        ready_n  = ready;
        reload_n = reload;
        if (reg_dat_re && ready) ready_n = 1'b0;
        case (state)
            IDLE: begin
                if (reload) begin
                    lfsr_n   = (seed[WIDTH-1:0] == '0) ? SEED_W : seed[WIDTH-1:0];
                    reload_n = 1'b0;
                    ready_n  = 1'b0;
                end else if (start) begin
                    state_n = SHIFT;
                    cnt_n   = 8'd0;
                end
            end
            SHIFT: begin
                lfsr_n = {lfsr[WIDTH-2:0], fb};
                cnt_n  = cnt + 8'd1;
                if (cnt == LAST) begin
                    state_n = DONE;
                    ready_n = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (|reg_seed_we) reload_n = 1'b1;
    end

    // state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            seed   <= SEED_DEFAULT;
            lfsr   <= SEED_W;
            cnt    <= 8'd0;
            ready  <= 1'b0;
            reload <= 1'b0;
        end else begin
            state  <= state_n;
            seed   <= seed_n;
            lfsr   <= lfsr_n;
            cnt    <= cnt_n;
            ready  <= ready_n;
            reload <= reload_n;
        end
    end
endmodule

// File: tb/tb_lfsr_prng_mm.sv
// tb_lfsr_prng_mm: directed bench for lfsr_prng_mm with a word-level reference model
module tb_lfsr_prng_mm;
`ifdef LFSR_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif
    localparam int IW  = PF ? 0 : 33;
    localparam int IW8 = PF ? 0 : 2;

    logic        clk = 1'b0, resetn = 1'b0;
    logic [3:0]  we0 = '0, we1 = '0;
    logic [31:0] di0 = '0, di1 = '0;
    logic        re0 = 1'b0, re1 = 1'b0;
    logic [31:0] sdo0, sdo1, do0, do1;
    logic        wt0, wt1;
    logic [31:0] mseed[2], mcur[2];
    logic [31:0] q0[$], q1[$];
    logic [31:0] d;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    lfsr_prng_mm dut (
        .clk(clk), .resetn(resetn), .reg_seed_we(we0), .reg_seed_di(di0), .reg_seed_do(sdo0),
        .reg_dat_re(re0), .reg_dat_do(do0), .reg_dat_wait(wt0)
    );

    lfsr_prng_mm #(.WIDTH(8), .TAPS(32'h0000_00B8), .STEPS(1)) dut8 (
        .clk(clk), .resetn(resetn), .reg_seed_we(we1), .reg_seed_di(di1), .reg_seed_do(sdo1),
        .reg_dat_re(re1), .reg_dat_do(do1), .reg_dat_wait(wt1)
    );

    function automatic logic [31:0] mask_of(input int sel);
        return (sel != 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    // n shifts of the spec's Fibonacci rule, computed on a plain masked integer
    function automatic logic [31:0] steps(input logic [31:0] v, input int sel);
        logic [31:0] m, taps, x;
        int n;
        m    = mask_of(sel);
        taps = (sel != 0) ? 32'h0000_00B8 : 32'h8020_0003;
        n    = (sel != 0) ? 1 : 32;
        x    = v;
        for (int i = 0; i < n; i++) x = ((x << 1) | 32'(^(x & taps))) & m;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_seed(input int sel, input logic [3:0] we, input logic [31:0] di);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            if (we[b]) mseed[sel][8*b +: 8] = di[8*b +: 8];
        if (we != 4'h0) begin
            r = mseed[sel] & mask_of(sel);
            mcur[sel] = (r == 32'h0) ? (32'hDEAD_BEEF & mask_of(sel)) : r;
        end
    endtask

    task automatic set_we(input int sel, input logic [3:0] we, input logic [31:0] di);
        if (sel != 0) begin we1 = we; di1 = di; end
        else begin we0 = we; di0 = di; end
    endtask

    task automatic set_re(input int sel, input logic v);
        if (sel != 0) re1 = v;
        else re0 = v;
    endtask

    task automatic gap();
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int sel, input logic [3:0] we, input logic [31:0] di, input string name);
        set_we(sel, we, di);
        @(posedge clk);
        #1;
        set_we(sel, 4'h0, 32'h0);
        apply_seed(sel, we, di);
        chk(name, (sel != 0) ? sdo1 : sdo0, mseed[sel]);
    endtask

    // one read transfer; optionally writes the seed on the wr_at-th stalled cycle
    task automatic rd(input int sel, input int exp_wait, input int wr_at, input logic [3:0] we,
                      input logic [31:0] di, input bit keep, output logic [31:0] dv, input string name);
        logic [31:0] e;
        int n;
        bit done, wrote;
        n = 0; done = 1'b0; wrote = 1'b0; dv = 32'h0;
        e = steps(mcur[sel], sel);
        if (sel != 0) q1.push_back(e);
        else q0.push_back(e);
        mcur[sel] = e;
        set_re(sel, 1'b1);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!((sel != 0) ? wt1 : wt0)) begin
                done = 1'b1;
                dv = (sel != 0) ? do1 : do0;
                break;
            end
            n++;
            if (n == wr_at) begin
                set_we(sel, we, di);
                wrote = 1'b1;
            end
            @(posedge clk);
            #1;
            set_we(sel, 4'h0, 32'h0);
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_wait"}, 32'(n), 32'(exp_wait));
        @(posedge clk);
        #1;
        if (!keep) set_re(sel, 1'b0);
        if (wrote) apply_seed(sel, we, di);
    endtask

    // every completed transfer must deliver the next word the model predicts
    always @(negedge clk) begin
        if (resetn && re0 && !wt0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dat0: got %h expected no transfer", do0);
            end else chk("dat0", do0, q0.pop_front());
        end
        if (resetn && re1 && !wt1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dat8: got %h expected no transfer", do1);
            end else chk("dat8", do1, q1.pop_front());
        end
    end

    initial begin
        mseed[0] = 32'hDEAD_BEEF; mseed[1] = 32'hDEAD_BEEF;
        mcur[0]  = 32'hDEAD_BEEF; mcur[1]  = 32'h0000_00EF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seed", sdo0, 32'hDEAD_BEEF);
        chk("rst_dat", do0, 32'hDEAD_BEEF);
        chk("rst_wait", 32'(wt0), 32'd0);
        chk("rst_dat8", do1, 32'h0000_00EF);
        resetn = 1'b1;
        wr(1, 4'hF, 32'h0000_0001, "t2_seed01");
        gap();
        rd(1, IW8, 0, 4'h0, 32'h0, 1'b0, d, "t2_r1");
        chk("t2_r1_lit", d, 32'h0000_0002);
        gap();
        rd(1, IW8, 0, 4'h0, 32'h0, 1'b0, d, "t2_r2");
        chk("t2_r2_lit", d, 32'h0000_0004);
        wr(1, 4'hF, 32'h0000_0080, "t2_seed80");
        gap();
        rd(1, IW8, 0, 4'h0, 32'h0, 1'b0, d, "t2_r3");
        chk("t2_r3_lit", d, 32'h0000_0001);
        gap();
        rd(0, IW, 0, 4'h0, 32'h0, 1'b0, d, "t1");
        chk("t1_seed_lit", sdo0, 32'hDEAD_BEEF);
        wr(0, 4'b0010, 32'h0000_AB00, "t4_seed");
        chk("t4_seed_lit", sdo0, 32'hDEAD_ABEF);
        gap();
        rd(0, IW, 0, 4'h0, 32'h0, 1'b0, d, "t4");
        wr(0, 4'hF, 32'h0, "t3_seed");
        gap();
        rd(0, IW, 0, 4'h0, 32'h0, 1'b0, d, "t3");
        gap();
        rd(0, IW, 0, 4'h0, 32'h0, 1'b0, d, "b2b_a");
        rd(0, 33, 0, 4'h0, 32'h0, 1'b0, d, "b2b_b");
        rd(0, 33, 5, 4'hF, 32'h1234_5678, 1'b0, d, "t5_old");
        chk("t5_seed_lit", sdo0, 32'h1234_5678);
        gap();
        rd(0, IW, 0, 4'h0, 32'h0, 1'b1, d, "t5_new");
        repeat (5) @(posedge clk);
        #1;
        re0 = 1'b0;
        gap();
        rd(0, 0, 0, 4'h0, 32'h0, 1'b1, d, "redrop");
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        re0 = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_seed", sdo0, 32'hDEAD_BEEF);
        chk("mid_rst_dat", do0, 32'hDEAD_BEEF);
        chk("mid_rst_wait", 32'(wt0), 32'd0);
        chk("mid_rst_seed8", sdo1, 32'hDEAD_BEEF);
        chk("mid_rst_dat8", do1, 32'h0000_00EF);
        resetn = 1'b1;
        mseed[0] = 32'hDEAD_BEEF; mseed[1] = 32'hDEAD_BEEF;
        mcur[0]  = 32'hDEAD_BEEF; mcur[1]  = 32'h0000_00EF;
        gap();
        rd(0, IW, 0, 4'h0, 32'h0, 1'b0, d, "after_rst");
        repeat (2) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q8_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
